debounce_bank: RTL and testbench

Parametrised multi-channel button conditioner replacing single-input debouncing for the SuperFrog user I/O. Each channel synchronises a raw pad input, debounces it over a programmable stable period, and emits a clean level plus one-cycle press/release strobes. Long-press (`hold`) and auto-repeat (`rpt`) strobes are also generated per channel. It sits between the board pins and the game/control FSMs, all in the single system clock domain.

---
 rtl/debounce_pkg.sv | 16 +
 rtl/debounce_chan.sv | 95 +++++++++
 rtl/debounce_bank.sv | 39 +++
 tb/tb_debounce_bank.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared hold-FSM state type, default timing constants and width helper
package debounce_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_HOLD, REPEAT} hold_state_t;

    localparam int DEF_CHANNELS        = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 262144;
    localparam int DEF_HOLD_CYCLES     = 50_000_000;
    localparam int DEF_REPEAT_CYCLES   = 10_000_000;
    localparam bit DEF_ACTIVE_LOW      = 1'b0;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one input conditioned through sync, debounce and hold/repeat strobes
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic ondn,
    output logic onup,
    output logic hold,
    output logic rpt
);

    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int DW = clog2_min1(DEBOUNCE_CYCLES);
    localparam int HW = clog2_min1(HMAX);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] R_LAST = HW'(REPEAT_CYCLES - 1);
    localparam bit HOLD_EN = HOLD_CYCLES != 0;
    localparam bit RPT_EN = REPEAT_CYCLES != 0;

    logic sync_0, sync_1, flip, rise, fall, hold_n, rpt_n;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt, hcnt_n;
    hold_state_t state, state_n;

    assign flip = (sync_1 != out) && (dcnt == D_LAST);
    assign rise = flip & ~out;
    assign fall = flip & out;

    // release wins over everything so hold/rpt can never share a cycle with onup
    always_comb begin
        state_n = state;
        hcnt_n = hcnt + 1'b1;
        hold_n = 1'b0;
        rpt_n = 1'b0;
        if (fall) begin
            state_n = IDLE;
            hcnt_n = '0;
        end else if (rise) begin
            state_n = HOLD_EN ? WAIT_HOLD : IDLE;
            hcnt_n = '0;
        end else begin
            case (state)
                IDLE: hcnt_n = '0;
                WAIT_HOLD: if (hcnt == H_LAST) begin
                    hold_n = 1'b1;
                    hcnt_n = '0;
                    state_n = REPEAT;
                end
                REPEAT: if (!RPT_EN) begin
                    hcnt_n = hcnt;
                end else if (hcnt == R_LAST) begin
                    rpt_n = 1'b1;
                    hcnt_n = '0;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_0 <= 1'b0;
            sync_1 <= 1'b0;
            dcnt <= '0;
            out <= 1'b0;
            ondn <= 1'b0;
            onup <= 1'b0;
            hold <= 1'b0;
            rpt <= 1'b0;
            hcnt <= '0;
            state <= IDLE;
        end else begin
            sync_0 <= in ^ ACTIVE_LOW;
            sync_1 <= sync_0;
            dcnt <= (sync_1 == out || flip) ? '0 : dcnt + 1'b1;
            out <= out ^ flip;
            ondn <= rise;
            onup <= fall;
            hold <= hold_n;
            rpt <= rpt_n;
            hcnt <= hcnt_n;
            state <= state_n;
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: CHANNELS independent button conditioners
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS        = DEF_CHANNELS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] ondn,
    output logic [CHANNELS-1:0] onup,
    output logic [CHANNELS-1:0] hold,
    output logic [CHANNELS-1:0] rpt
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES(HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_chan (
            .clk(clk),
            .rst(rst),
            .in(in[i]),
            .out(out[i]),
            .ondn(ondn[i]),
            .onup(onup[i]),
            .hold(hold[i]),
            .rpt(rpt[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: random press/bounce/reset stimulus against a window-based reference model
module tb_debounce_bank;

    localparam int CH = 4;
    localparam int DB = 4;
    localparam int HC = 20;
    localparam int RC = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [CH-1:0] drv = '0;
    logic [CH-1:0] pad_lo;
    logic [CH-1:0] out_hi, ondn_hi, onup_hi, hold_hi, rpt_hi;
    logic [CH-1:0] out_lo, ondn_lo, onup_lo, hold_lo, rpt_lo;

    assign pad_lo = ~drv;

    always #5 clk = ~clk;

    debounce_bank #(.CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC),
                    .REPEAT_CYCLES(RC), .ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .in(drv), .out(out_hi), .ondn(ondn_hi),
        .onup(onup_hi), .hold(hold_hi), .rpt(rpt_hi));

    debounce_bank #(.CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC),
                    .REPEAT_CYCLES(RC), .ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .in(pad_lo), .out(out_lo), .ondn(ondn_lo),
        .onup(onup_lo), .hold(hold_lo), .rpt(rpt_lo));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // model: out flips once the last DB sampled sync levels all disagree with it;
    // hold/rpt follow from the age of the current press
    logic [CH-1:0] m_s0, m_s1, m_out, e_ondn, e_onup, e_hold, e_rpt;
    logic [DB-1:0] hist [CH];
    int press_t [CH];

    task automatic check(input string tag, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h at t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic void model_clear();
        m_s0 = '0;
        m_s1 = '0;
        m_out = '0;
        e_ondn = '0;
        e_onup = '0;
        e_hold = '0;
        e_rpt = '0;
        for (int c = 0; c < CH; c++) begin
            hist[c] = '0;
            press_t[c] = 0;
        end
    endfunction

    task automatic compare();
        check("hi.out", int'(out_hi), int'(m_out));
        check("hi.ondn", int'(ondn_hi), int'(e_ondn));
        check("hi.onup", int'(onup_hi), int'(e_onup));
        check("hi.hold", int'(hold_hi), int'(e_hold));
        check("hi.rpt", int'(rpt_hi), int'(e_rpt));
        check("lo.out", int'(out_lo), int'(m_out));
        check("lo.ondn", int'(ondn_lo), int'(e_ondn));
        check("lo.onup", int'(onup_lo), int'(e_onup));
        check("lo.hold", int'(hold_lo), int'(e_hold));
        check("lo.rpt", int'(rpt_lo), int'(e_rpt));
    endtask

    task automatic step();
        logic flip;
        int age;
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_clear();
        end else begin
            for (int c = 0; c < CH; c++) begin
                hist[c] = {hist[c][DB-2:0], m_s1[c]};
                flip = m_out[c] ? (hist[c] == '0) : (hist[c] == '1);
                e_ondn[c] = flip & ~m_out[c];
                e_onup[c] = flip & m_out[c];
                if (e_ondn[c]) press_t[c] = cyc;
                m_out[c] = m_out[c] ^ flip;
                age = cyc - press_t[c];
                e_hold[c] = m_out[c] && age == HC;
                e_rpt[c] = m_out[c] && age > HC && (age - HC) % RC == 0;
                m_s1[c] = m_s0[c];
                m_s0[c] = drv[c];
            end
        end
        #1;
        compare();
    endtask

    task automatic pulse_rst(input int n);
        rst = 1'b1;
        #1;
        model_clear();
        compare();
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic measure_press(input string tag, input int want);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!out_hi[0] && n < 30);
        check(tag, n, want);
        check({tag, ".ondn"}, int'(ondn_hi), 1);
        check({tag, ".lo"}, int'(out_lo), 1);
    endtask

    initial begin
        int len;
        model_clear();
        #1;
        compare();
        repeat (3) step();
        rst = 1'b0;
        step();
        drv = 4'b0001;
        measure_press("lat", 6);
        repeat (2) step();
        pulse_rst(2);
        measure_press("lat_rst", 6);
        drv = '0;
        repeat (10) step();
        drv = 4'b1001;
        repeat (8) step();
        drv = 4'b0001;
        repeat (8) step();
        drv = '0;
        repeat (8) step();
        for (int p = 0; p < 70; p++) begin
            repeat ($urandom_range(0, 5)) begin
                drv = CH'($urandom);
                step();
            end
            drv = CH'($urandom);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 70) : $urandom_range(1, 12);
            repeat (len) step();
            if ($urandom_range(0, 11) == 0) pulse_rst($urandom_range(1, 3));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
